// File: rtl/sensor_uart_pkg.sv
// Shared types and constants for the sensor UART packet receive path.
// Pure declarations; no timing or flow control of its own.
package sensor_uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    DRAIN
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Index width for an n-entry range, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_pkt_buf.sv
// Payload store: MAX_LEN x 8 register array, one synchronous write port.
// Read port is combinational (zero latency); no flow control, contents are not reset.
module sensor_pkt_buf
  import sensor_uart_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int PTR_W   = idx_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sensor_pkt_rx.sv
// Sync-hunting frame decoder; payload is buffered and released only after the checksum matches.
// All outputs registered one cycle after the input strobe; out stream holds under !out_ready, bytes arriving while draining are dropped.
module sensor_pkt_rx
  import sensor_uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 17360,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int               PTR_W     = idx_width(MAX_LEN);
  localparam int               TMO_W     = idx_width(TIMEOUT_CYCLES);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] last_idx_q, last_idx_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [7:0]       acc_q, acc_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [7:0]       out_data_d;
  logic             out_valid_d, out_last_d;
  logic             frame_ok_d, frame_err_d;
  logic [1:0]       err_code_d;

  logic             buf_we;
  logic [PTR_W-1:0] buf_raddr;
  logic [7:0]       buf_rdata;

  logic             timed, tmo_hit;
  logic [PTR_W-1:0] rptr_nxt;

  sensor_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .PTR_W   (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // A byte in the expiry cycle takes priority over the timeout.
  assign timed    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
  assign tmo_hit  = timed && !in_valid && (tmo_q == TMO_LAST);
  assign rptr_nxt = rptr_q + PTR_ONE;

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    acc_d       = acc_q;
    tmo_d       = (timed && !in_valid && !tmo_hit) ? tmo_q + TMO_ONE : '0;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    buf_we      = 1'b0;
    buf_raddr   = '0;

    case (state_q)
      HUNT: begin
        if (in_valid && (in_data == SYNC_BYTE)) begin
          acc_d   = '0;
          state_d = LEN;
        end
      end

      LEN: begin
        if (in_valid) begin
          if ((in_data == 8'd0) || (in_data > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = HUNT;
          end else begin
            last_idx_d = PTR_W'(in_data - 8'd1);
            acc_d      = in_data;
            wptr_d     = '0;
            state_d    = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          acc_d  = acc_q + in_data;
          if (wptr_q == last_idx_q) begin
            state_d = CHECK;
          end else begin
            wptr_d = wptr_q + PTR_ONE;
          end
        end
      end

      CHECK: begin
        if (in_valid) begin
          if (in_data == acc_q) begin
            frame_ok_d  = 1'b1;
            rptr_d      = '0;
            out_valid_d = 1'b1;
            out_data_d  = buf_rdata;
            out_last_d  = (last_idx_q == '0);
            state_d     = DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = HUNT;
          end
        end
      end

      DRAIN: begin
        // Prefetch the following byte so a transfer can be replaced next cycle.
        buf_raddr = rptr_nxt;
        if (in_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = HUNT;
          end else begin
            rptr_d     = rptr_nxt;
            out_data_d = buf_rdata;
            out_last_d = (rptr_nxt == last_idx_q);
          end
        end
      end

      default: state_d = HUNT;
    endcase

    if (tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      last_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      frame_ok   <= frame_ok_d;
      frame_err  <= frame_err_d;
      err_code   <= err_code_d;
      busy       <= (state_d != HUNT);
    end
  end

endmodule

// File: tb/tb_sensor_pkt_rx.sv
// Directed bench for sensor_pkt_rx: hand-computed frames, pulse counters and a transfer log.
module tb_sensor_pkt_rx;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_ok, frame_err, busy;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;
  int ok_pulses = 0;
  int err_pulses = 0;
  int both_pulses = 0;
  logic [8:0] got [$];

  always #5 clk = ~clk;

  sensor_pkt_rx #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (frame_ok) ok_pulses++;
    if (frame_err) err_pulses++;
    if (frame_ok && frame_err) both_pulses++;
    if (out_valid && out_ready) got.push_back({out_last, out_data});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64 && busy; i++) tick();
    check(tag, busy, 0);
  endtask

  // bytes holds payload byte i at bits [8*i +: 8]; last flag expected on byte n-1.
  task automatic check_drain(input string tag, input int base, input int n, input logic [31:0] bytes);
    check({tag, "_count"}, got.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < got.size()) check(tag, got[base + i], {(i == n - 1), bytes[8*i +: 8]});
    end
  endtask

  int base;

  initial begin
    tick();
    tick();
    check("reset_outputs", {out_valid, out_last, frame_ok, frame_err, busy, err_code, out_data}, 0);
    rst_n = 1'b1;
    tick();

    // Good 3-byte frame, consumer always ready.
    out_ready = 1'b1;
    base = got.size();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("t1_busy_mid", busy, 1);
    send_byte(8'h69);
    check("t1_ok", {frame_ok, frame_err, out_valid, out_last, out_data}, {4'b1010, 8'h11});
    tick();
    check("t1_b1", {frame_ok, out_valid, out_last, out_data}, {3'b010, 8'h22});
    tick();
    check("t1_b2", {out_valid, out_last, busy, out_data}, {3'b111, 8'h33});
    tick();
    check("t1_done", {out_valid, busy}, 2'b00);
    check_drain("t1_log", base, 3, 32'h00_33_22_11);

    // Bad checksum, then a good 2-byte frame.
    base = got.size();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h6A);
    check("t2_err", {frame_ok, frame_err, err_code, out_valid, busy}, 6'b01_10_00);
    tick(); tick();
    check("t2_no_out", got.size() - base, 0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    check("t2_ok", frame_ok, 1);
    wait_idle("t2_idle");
    check_drain("t2_log", base, 2, 32'h00_00_02_01);

    // Zero and oversize lengths.
    send_byte(8'hA5); send_byte(8'h00);
    check("t3_len0", {frame_err, err_code, busy}, 4'b1_00_0);
    tick();
    send_byte(8'hA5); send_byte(8'h11);
    check("t3_len17", {frame_err, err_code, busy}, 4'b1_00_0);
    tick();

    // Timeout after TMO silent cycles.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("t4_pre_expiry", {frame_err, busy}, 2'b01);
    tick();
    check("t4_timeout", {frame_err, err_code, busy}, 4'b1_01_0);
    tick();

    // A byte landing on the expiry cycle wins.
    base = got.size();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    for (int i = 0; i < TMO - 1; i++) tick();
    send_byte(8'h22);
    check("t4_byte_wins", {frame_err, busy}, 2'b01);
    send_byte(8'h35);
    check("t4_ok", {frame_ok, frame_err}, 2'b10);
    wait_idle("t4_idle");
    check_drain("t4_log", base, 2, 32'h00_00_22_11);

    // Garbage ignored, then a 1-byte frame held under backpressure with an overrun.
    out_ready = 1'b0;
    base = got.size();
    send_byte(8'h00); send_byte(8'hFF);
    check("t5_garbage", {frame_err, busy}, 2'b00);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("t5_ok", {frame_ok, out_valid, out_last, out_data}, {3'b111, 8'h7E});
    tick();
    send_byte(8'h55);
    check("t5_overrun", {frame_err, err_code, out_valid, out_data}, {4'b1_11_1, 8'h7E});
    tick(); tick();
    check("t5_hold", {out_valid, out_last, out_data}, {2'b11, 8'h7E});
    out_ready = 1'b1;
    tick();
    check("t5_released", {out_valid, busy}, 2'b00);
    check_drain("t5_log", base, 1, 32'h00_00_00_7E);

    // Reset in the middle of a frame.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", {out_valid, out_last, frame_ok, frame_err, busy, err_code, out_data}, 0);
    tick();
    check("t6_in_reset", {out_valid, frame_err, busy}, 3'b000);
    rst_n = 1'b1;
    tick();
    base = got.size();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    check("t6_ok", {frame_ok, out_valid, out_data}, {2'b11, 8'h11});
    wait_idle("t6_idle");
    check_drain("t6_log", base, 3, 32'h00_33_22_11);

    tick();
    check("ok_pulse_total", ok_pulses, 5);
    check("err_pulse_total", err_pulses, 5);
    check("ok_err_overlap", both_pulses, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
